// File: rtl/fifo_ram_dxw_p1p1.sv
// fifo_ram_dxw_p1p1: first-word-fall-through FIFO on a dual-port RAM with a 2-entry output buffer
// ram_dxw_rrw_p1p1 : true dual-port RAM, registered read on both ports (1-cycle latency)
// fifo_ram_dxw_p1p1: clock/reset, in_valid/in_ready/in_data push side,
//                    out_valid/out_ready/out_data pop side, level = words held (0..DEPTH)
module ram_dxw_rrw_p1p1 #(
    parameter int DEPTH     = 4096,
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic [ADDR_BITS-1:0] address_a,
    input  logic [WIDTH-1:0]     data_a,
    input  logic                 wren_a,
    output logic [WIDTH-1:0]     q_a,
    input  logic [ADDR_BITS-1:0] address_b,
    input  logic [WIDTH-1:0]     data_b,
    input  logic                 wren_b,
    output logic [WIDTH-1:0]     q_b
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clock) begin
        if (wren_a) mem[address_a] <= data_a;
        if (wren_b) mem[address_b] <= data_b;
        q_a <= mem[address_a];
        q_b <= mem[address_b];
    end
endmodule

module fifo_ram_dxw_p1p1 #(
    parameter int DEPTH      = 4096,
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [DEPTH_BITS:0]   level
);
    localparam int LW = DEPTH_BITS + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0]         ram_count;
    logic                  rd_pending, push, pop, rd_issue;
    logic [1:0]            buf_occ, occ_after_pop;
    logic [2:0]            committed;
    logic [WIDTH-1:0]      buf0, buf1, q_b, unused_q_a;
    assign in_ready      = !reset && (level < FULL);
    assign out_valid     = buf_occ != 2'd0;
    assign out_data      = buf0;
    assign push          = in_valid && in_ready;
    assign pop           = out_valid && out_ready;
    assign occ_after_pop = buf_occ - {1'b0, pop};
    // buffer slots already spoken for once this edge's pop is taken out
    assign committed     = {1'b0, occ_after_pop} + {2'b00, rd_pending};
    assign rd_issue      = (ram_count != '0) && (committed < 3'd2);
    ram_dxw_rrw_p1p1 #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_BITS(DEPTH_BITS)) u_ram (
        .clock     (clock),
        .address_a (wr_ptr),
        .data_a    (in_data),
        .wren_a    (push),
        .q_a       (unused_q_a),
        .address_b (rd_ptr),
        .data_b    ('0),
        .wren_b    (1'b0),
        .q_b       (q_b)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_count  <= '0;
            level      <= '0;
            rd_pending <= 1'b0;
            buf_occ    <= 2'd0;
            buf0       <= '0;
            buf1       <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            if (rd_issue) rd_ptr <= rd_ptr + DEPTH_BITS'(1);
            ram_count  <= ram_count + LW'(push) - LW'(rd_issue);
            level      <= level + LW'(push) - LW'(pop);
            rd_pending <= rd_issue;
            buf_occ    <= committed[1:0];
            // returning word lands in the first slot left free after the pop shift
            buf0 <= (pop && buf_occ == 2'd2) ? buf1 :
                    (rd_pending && occ_after_pop == 2'd0) ? q_b : buf0;
            buf1 <= (rd_pending && occ_after_pop == 2'd1) ? q_b : buf1;
        end
    end
endmodule

// File: tb/tb_fifo_ram_dxw_p1p1.sv
// tb_fifo_ram_dxw_p1p1: directed self-checking bench for the FWFT FIFO (DEPTH=16 build)
module tb_fifo_ram_dxw_p1p1;
    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] out_data;
    logic [4:0]       level;
    int checks = 0;
    int errors = 0;
    int exp_v, sent, recv, pushes, pops;
    logic acc, pp, stall;
    logic [WIDTH-1:0] held;

    fifo_ram_dxw_p1p1 #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_out_data", out_data, 0);
        tick;
        tick;
        reset = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);
        tick;
        // reset mid-stream after 5 pushes
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'h10 + i);
            tick;
        end
        in_valid = 1'b0;
        chk("mid_pre_level", level, 5);
        chk("mid_pre_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        tick;
        reset = 1'b0;
        tick;
        chk("mid_rel_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("mid_no_stale", out_valid, 0);
        end
        // single word latency
        in_valid = 1'b1;
        in_data = 8'hA5;
        tick;
        in_valid = 1'b0;
        chk("sw_e0_level", level, 1);
        chk("sw_e0_valid", out_valid, 0);
        tick;
        chk("sw_e1_valid", out_valid, 0);
        tick;
        chk("sw_e2_valid", out_valid, 1);
        chk("sw_e2_data", out_data, 8'hA5);
        chk("sw_e2_level", level, 1);
        tick;
        chk("sw_pop_valid", out_valid, 0);
        chk("sw_pop_level", level, 0);
        chk("sw_hold_data", out_data, 8'hA5);
        // streaming 0x00..0xFF
        for (int j = 0; j < 260; j++) begin
            in_valid = j < 256;
            in_data = 8'(j);
            tick;
            pushes = (j + 1 > 256) ? 256 : j + 1;
            pops = ((j > 258) ? 258 : j) - 2;
            if (pops < 0) pops = 0;
            chk("str_valid", out_valid, (j >= 2 && j <= 257));
            if (j >= 2 && j <= 257) chk("str_data", out_data, j - 2);
            chk("str_level", level, pushes - pops);
        end
        in_valid = 1'b0;
        // fill to full with no pops
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_data = 8'(k);
            tick;
            chk("fill_level", level, k + 1);
            chk("fill_in_ready", in_ready, k < 15);
        end
        in_data = 8'd16;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("full_level", level, 16);
            chk("full_in_ready", in_ready, 0);
            chk("full_stall_valid", out_valid, 1);
            chk("full_stall_data", out_data, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("pop1_level", level, 15);
        chk("pop1_in_ready", in_ready, 1);
        exp_v = 1;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && exp_v < 16; c++) begin
            if (out_valid) begin
                chk("drain_data", out_data, exp_v);
                exp_v++;
            end
            tick;
        end
        out_ready = 1'b0;
        chk("drain_count", exp_v, 16);
        chk("drain_level", level, 0);
        chk("drain_valid", out_valid, 0);
        // wrap with random backpressure
        sent = 0;
        recv = 0;
        for (int c = 0; c < 3000 && recv < 100; c++) begin
            in_valid = sent < 100;
            in_data = 8'(sent);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_valid && in_ready;
            pp = out_valid && out_ready;
            stall = out_valid && !out_ready;
            held = out_data;
            if (out_valid) chk("wrap_data", out_data, recv);
            tick;
            if (acc) sent++;
            if (pp) recv++;
            if (stall) begin
                chk("wrap_stall_valid", out_valid, 1);
                chk("wrap_stall_data", out_data, held);
            end
            chk("wrap_level", level, sent - recv);
            chk("wrap_level_max", level <= 5'd16, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("wrap_count", recv, 100);
        chk("wrap_end_level", level, 0);
        // simultaneous push/pop at level 1
        in_valid = 1'b1;
        in_data = 8'h30;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("s1_valid", out_valid, 1);
        chk("s1_level", level, 1);
        chk("s1_head", out_data, 8'h30);
        in_valid = 1'b1;
        in_data = 8'h31;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("s1_level_after", level, 1);
        for (int c = 0; c < 10 && !out_valid; c++) tick;
        chk("s1_next_valid", out_valid, 1);
        chk("s1_next_data", out_data, 8'h31);
        tick;
        out_ready = 1'b0;
        chk("s1_empty_level", level, 0);
        // simultaneous push/pop at level DEPTH-1
        in_valid = 1'b1;
        for (int k = 0; k < 15; k++) begin
            in_data = 8'(8'h40 + k);
            tick;
        end
        in_valid = 1'b0;
        chk("s15_level", level, 15);
        chk("s15_in_ready", in_ready, 1);
        chk("s15_head", out_data, 8'h40);
        in_valid = 1'b1;
        in_data = 8'h4F;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("s15_level_after", level, 15);
        exp_v = 8'h41;
        for (int c = 0; c < 60 && exp_v <= 8'h4F; c++) begin
            if (out_valid) begin
                chk("s15_drain_data", out_data, exp_v);
                exp_v++;
            end
            tick;
        end
        out_ready = 1'b0;
        chk("s15_drain_count", exp_v, 8'h50);
        chk("s15_end_level", level, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
